// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and sequencer feeding an 8-bit combinational ALU
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic              cmd_acc,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
  output logic              res_zero,
  output logic              busy,
  output logic              err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 4 + 1 + 2 * DATA_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  logic [3:0]        head_op;
  logic              head_acc;
  logic [DATA_W-1:0] head_a, head_b, op_a;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] prod, mcand, mplier, prod_nxt;
  logic [2:0]        cnt;

  assign cmd_ready = ena && (count < DEPTH_C);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = ena && (state_q == IDLE) && (count != '0);
  assign busy      = (state_q != IDLE) || (count != '0);

  assign {head_op, head_acc, head_a, head_b} = fifo_mem[rd_ptr];
  assign op_a     = head_acc ? acc : head_a;
  // During MUL the ALU is wired as prod + mcand, so alu_y is the candidate sum
  assign prod_nxt = mplier[0] ? alu_y : prod;

  // FIFO storage; entries beyond count are don't-care, so no reset is needed here
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_op, cmd_acc, cmd_a, cmd_b};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state; everything holds while ena is low
  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            if (!head_op[3])          state_d = EXEC;
            else if (head_op == 4'd8) state_d = MUL;
            else                      state_d = IDLE;
          end
        end
        EXEC:    state_d = HOLD;
        MUL:     if (cnt == 3'd7) state_d = HOLD;
        HOLD:    if (res_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: ALU operand registers, shift-add multiplier, result and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      err       <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            if (!head_op[3]) begin
              alu_op <= head_op[2:0];
              alu_a  <= op_a;
              alu_b  <= head_b;
            end else if (head_op == 4'd8) begin
              prod   <= '0;
              mcand  <= op_a;
              mplier <= head_b;
              cnt    <= '0;
              alu_op <= 3'd0;
              alu_a  <= '0;
              alu_b  <= op_a;
            end else begin
              err <= 1'b1;
            end
          end
        end
        EXEC: begin
          res_data  <= alu_y;
          res_carry <= alu_c;
          res_zero  <= (alu_y == '0);
          res_valid <= 1'b1;
        end
        MUL: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          alu_a  <= prod_nxt;
          alu_b  <= mcand << 1;
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            res_data  <= prod_nxt;
            res_carry <= 1'b0;
            res_zero  <= (prod_nxt == '0);
            res_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            acc       <= res_data;
            res_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - scoreboard testbench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic       cmd_acc;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_c;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       res_carry, res_zero;
  logic       busy, err;

  typedef struct {
    logic [7:0] d;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_hs    = 0;

  alu_cmd_sequencer #(.FIFO_DEPTH(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_acc(cmd_acc), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU
  always_comb begin
    alu_y = 8'h00;
    alu_c = 1'b0;
    case (alu_op)
      3'd0: {alu_c, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: {alu_c, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_y = alu_a & alu_b;
      3'd3: alu_y = alu_a | alu_b;
      3'd4: alu_y = alu_a ^ alu_b;
      3'd5: {alu_c, alu_y} = {alu_a, 1'b0};
      3'd6: {alu_y, alu_c} = {1'b0, alu_a};
      default: alu_y = alu_b;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: every handshake pops one expected result and compares it
  always @(negedge clk) begin
    if (rst_n && ena && res_valid && res_ready) begin
      n_hs++;
      if (sb.size() == 0) begin
        timeout("unexpected_result");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", 32'(res_data), 32'(e.d));
        check("res_carry", 32'(res_carry), 32'(e.c));
        check("res_zero", 32'(res_zero), 32'(e.z));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic acc, input logic [7:0] a, input logic [7:0] b,
                      input logic legal, input logic [7:0] ed, input logic ec, input logic ez);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      timeout("send_ready");
    end else begin
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_acc   = acc;
      cmd_a     = a;
      cmd_b     = b;
      if (legal) sb.push_back('{ed, ec, ez});
      tick();
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || res_valid) && n < 300) begin
      tick();
      n++;
    end
    if (busy || res_valid) timeout("wait_idle");
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!res_valid && n < 50) begin
      tick();
      n++;
    end
    if (!res_valid) timeout("wait_valid");
  endtask

  initial begin
    int hs0;
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_acc = 1'b0;
    cmd_a = 8'h00; cmd_b = 8'h00; res_ready = 1'b0;
    repeat (3) tick();
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_alu", 32'({alu_op, alu_a, alu_b}), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // ADD latency and accumulator
    send(4'd0, 1'b0, 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b0);
    check("add_valid_E", 32'(res_valid), 32'd0);
    tick();
    check("add_valid_E1", 32'(res_valid), 32'd0);
    check("add_busy_E1", 32'(busy), 32'd1);
    check("add_operands_E1", 32'({alu_op, alu_a, alu_b}), 32'({3'd0, 8'h7F, 8'h01}));
    tick();
    check("add_valid_E2", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    wait_idle();
    send(4'd3, 1'b1, 8'h00, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0);
    wait_idle();

    // SUB to zero, then XOR on accumulator
    send(4'd1, 1'b0, 8'h05, 8'h05, 1'b1, 8'h00, 1'b0, 1'b1);
    send(4'd4, 1'b1, 8'hAA, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0);
    wait_idle();

    // MUL latency and results
    res_ready = 1'b0;
    send(4'd8, 1'b0, 8'h0D, 8'h0B, 1'b1, 8'h8F, 1'b0, 1'b0);
    repeat (8) tick();
    check("mul_valid_E8", 32'(res_valid), 32'd0);
    tick();
    check("mul_valid_E9", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    wait_idle();
    send(4'd8, 1'b0, 8'h10, 8'h10, 1'b1, 8'h00, 1'b0, 1'b1);
    wait_idle();

    // Fill FIFO with the consumer stalled, then drain
    res_ready = 1'b0;
    hs0 = n_hs;
    send(4'd0, 1'b0, 8'h01, 8'h02, 1'b1, 8'h03, 1'b0, 1'b0);
    send(4'd2, 1'b0, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0);
    send(4'd3, 1'b0, 8'h0F, 8'hF0, 1'b1, 8'hFF, 1'b0, 1'b0);
    send(4'd5, 1'b0, 8'h81, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0);
    send(4'd6, 1'b0, 8'h03, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    check("full_cmd_ready_hold", 32'(cmd_ready), 32'd0);
    res_ready = 1'b1;
    wait_idle();
    check("drain_count", 32'(n_hs - hs0), 32'd5);
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_cmd_ready", 32'(cmd_ready), 32'd1);

    // Illegal opcode between two ADDs
    hs0 = n_hs;
    send(4'd0, 1'b0, 8'h0A, 8'h14, 1'b1, 8'h1E, 1'b0, 1'b0);
    send(4'hA, 1'b0, 8'h11, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0);
    send(4'd0, 1'b0, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1);
    wait_idle();
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_results", 32'(n_hs - hs0), 32'd2);
    send(4'd7, 1'b0, 8'h00, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0);
    wait_idle();
    check("err_sticky", 32'(err), 32'd1);

    // Reset in the middle of MUL with two commands queued
    res_ready = 1'b0;
    send(4'd8, 1'b0, 8'h0D, 8'h0B, 1'b1, 8'h8F, 1'b0, 1'b0);
    send(4'd0, 1'b0, 8'h01, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0);
    send(4'd0, 1'b0, 8'h02, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0);
    repeat (3) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    send(4'd0, 1'b1, 8'hFF, 8'h05, 1'b1, 8'h05, 1'b0, 1'b0);
    res_ready = 1'b1;
    wait_idle();

    // ena low while holding a result
    res_ready = 1'b0;
    send(4'd7, 1'b0, 8'h00, 8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0);
    wait_valid();
    hs0 = n_hs;
    ena = 1'b0;
    res_ready = 1'b1;
    repeat (3) tick();
    check("ena_res_valid", 32'(res_valid), 32'd1);
    check("ena_res_data", 32'(res_data), 32'h5A);
    check("ena_cmd_ready", 32'(cmd_ready), 32'd0);
    check("ena_no_handshake", 32'(n_hs - hs0), 32'd0);
    ena = 1'b1;
    wait_idle();
    check("ena_resume_handshake", 32'(n_hs - hs0), 32'd1);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
